madd_seq: RTL



---
 rtl/madd_pkg.sv | 14 +
 rtl/madd_pp_mask.sv | 30 +++
 rtl/madd_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/madd_pkg.sv
// Shared types and helpers for the sequential multiply-add block.
package madd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    function automatic int unsigned res_w(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/madd_pp_mask.sv
// Partial-product mask: clears the low TRUNC_K columns when MADD_TRUNC_EN is defined,
// otherwise passes the shifted multiplicand through untouched.
module madd_pp_mask
    import madd_pkg::*;
#(
    parameter int unsigned W       = 3,
    parameter int unsigned TRUNC_K = 2
) (
    input  logic [res_w(W)-1:0] a_sh,
    output logic [res_w(W)-1:0] pp
);

    if (TRUNC_K >= res_w(W)) begin : g_bad_trunc
        $error("madd_pp_mask: TRUNC_K must be below 2*W");
    end

`ifdef MADD_TRUNC_EN
    always_comb begin
        pp = a_sh;
        for (int unsigned i = 0; i < res_w(W); i++) begin
            if (i < TRUNC_K) begin
                pp[i] = 1'b0;
            end
        end
    end
`else
    assign pp = a_sh;
`endif

endmodule

// File: rtl/madd_seq.sv
// Iterative shift-add multiply-add, result = a*b + (in_acc ? acc : c), with valid/ready on
// both sides. Defining MADD_TRUNC_EN turns it into a truncated multiplier (TRUNC_K columns).
module madd_seq
    import madd_pkg::*;
#(
    parameter int unsigned W       = 3,
    parameter int unsigned TRUNC_K = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_a,
    input  logic [W-1:0]        in_b,
    input  logic [W-1:0]        in_c,
    input  logic                in_acc,
    input  logic                acc_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [res_w(W)-1:0] out_result
);

    localparam int unsigned ResW = res_w(W);
    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    if (W < 2) begin : g_bad_w
        $error("madd_seq: W must be at least 2");
    end

    state_e            state_q;
    logic [ResW-1:0]   a_sh_q;
    logic [W-1:0]      b_sh_q;
    logic [ResW-1:0]   sum_q;
    logic [ResW-1:0]   sum_d;
    logic [CntW-1:0]   cnt_q;
    logic [ResW-1:0]   acc_q;
    logic              out_valid_q;
    logic [ResW-1:0]   out_result_q;
    logic [ResW-1:0]   pp;

    madd_pp_mask #(
        .W       (W),
        .TRUNC_K (TRUNC_K)
    ) u_pp_mask (
        .a_sh (a_sh_q),
        .pp   (pp)
    );

    always_comb begin
        sum_d = sum_q;
        if (b_sh_q[0]) begin
            sum_d = sum_q + pp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            // A result write later in this block overrides a coincident clear.
            if (acc_clr) begin
                acc_q <= '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_sh_q  <= {{W{1'b0}}, in_a};
                        b_sh_q  <= in_b;
                        sum_q   <= in_acc ? acc_q : {{W{1'b0}}, in_c};
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    sum_q  <= sum_d;
                    a_sh_q <= a_sh_q << 1;
                    b_sh_q <= b_sh_q >> 1;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_q      <= StDone;
                        out_result_q <= sum_d;
                        acc_q        <= sum_d;
                        out_valid_q  <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;

endmodule
